// File: rtl/alu_bundle_issue_pkg.sv
// alu_pkg: shared definitions for the bundle issue block.
// Holds the opcode width, the four legal ALU opcodes, the highest legal
// opcode value and the issue FSM state type.
package alu_pkg;

  localparam int OPW = 12;

  typedef logic [OPW-1:0] opcode_t;

  localparam opcode_t OP_ADD       = 12'd0;
  localparam opcode_t OP_XOR       = 12'd1;
  localparam opcode_t OP_AND       = 12'd2;
  localparam opcode_t OP_OR        = 12'd3;
  localparam opcode_t OP_MAX_LEGAL = 12'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Opcodes above the legal range are still issued, but get flagged.
  function automatic logic isIllegal(input opcode_t op);
    return op > OP_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/alu_bundle_issue_if.sv
// alu_bundle_issue_if: groups the bundle handshake, the external ALU
// connection and the result handshake.
//   bundleValid/bundleReady            producer -> block handshake
//   bundleEnable/bundleOp/bundleA/B    per-slot bundle contents
//   aluA/aluB/aluOp -> aluQ            combinational external ALU
//   resultValid/resultReady            block -> consumer handshake
//   resultQ/resultMask/resultIllegal   per-slot results
// The slave modport is the block's view; master is the environment's.
interface alu_bundle_issue_if #(
  parameter int OPERANDSIZE = 64,
  parameter int SLOTS       = 4
);
  import alu_pkg::*;

  logic                                 bundleValid;
  logic                                 bundleReady;
  logic [SLOTS-1:0]                     bundleEnable;
  logic [SLOTS-1:0][OPW-1:0]            bundleOp;
  logic [SLOTS-1:0][OPERANDSIZE-1:0]    bundleA;
  logic [SLOTS-1:0][OPERANDSIZE-1:0]    bundleB;

  logic [OPERANDSIZE-1:0]               aluA;
  logic [OPERANDSIZE-1:0]               aluB;
  logic [OPW-1:0]                       aluOp;
  logic [OPERANDSIZE-1:0]               aluQ;

  logic                                 resultValid;
  logic                                 resultReady;
  logic [SLOTS-1:0][OPERANDSIZE-1:0]    resultQ;
  logic [SLOTS-1:0]                     resultMask;
  logic [SLOTS-1:0]                     resultIllegal;

  modport slave (
    input  bundleValid, bundleEnable, bundleOp, bundleA, bundleB,
    input  aluQ, resultReady,
    output bundleReady, aluA, aluB, aluOp,
    output resultValid, resultQ, resultMask, resultIllegal
  );

  modport master (
    output bundleValid, bundleEnable, bundleOp, bundleA, bundleB,
    output aluQ, resultReady,
    input  bundleReady, aluA, aluB, aluOp,
    input  resultValid, resultQ, resultMask, resultIllegal
  );

endinterface

// File: rtl/alu_bundle_issue_next_slot.sv
// alu_next_slot: combinational lowest-set-bit finder.
//   enable   slots enabled in the latched bundle
//   issued   slots already sent to the ALU
//   index    lowest slot that is enabled and not yet issued
//   any      at least one such slot exists (index is 0 otherwise)
module alu_next_slot #(
  parameter int SLOTS = 4,
  parameter int IDXW  = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic [SLOTS-1:0] enable,
  input  logic [SLOTS-1:0] issued,
  output logic [IDXW-1:0]  index,
  output logic             any
);

  logic [SLOTS-1:0] pending;

  assign pending = enable & ~issued;
  assign any     = |pending;

  // Scanning from the top down leaves the lowest pending slot last written.
  always_comb begin
    index = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        index = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_bundle_issue.sv
// alu_bundle_issue: accepts a bundle of SLOTS ALU operations, issues the
// enabled ones one per cycle to an external combinational ALU, collects
// the results and offers them as a single result bundle.
//   clk, rstN   clock and synchronous active-low reset
//   bus         alu_bundle_issue_if slave: bundle in, ALU, results out
module alu_bundle_issue #(
  parameter int OPERANDSIZE = 64,
  parameter int SLOTS       = 4
) (
  input  logic               clk,
  input  logic               rstN,
  alu_bundle_issue_if.slave  bus
);
  import alu_pkg::*;

  localparam int IDXW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  state_t                            state_q, state_d;
  logic [SLOTS-1:0]                  enable_q, enable_d;
  logic [SLOTS-1:0][OPW-1:0]         op_q, op_d;
  logic [SLOTS-1:0][OPERANDSIZE-1:0] a_q, a_d;
  logic [SLOTS-1:0][OPERANDSIZE-1:0] b_q, b_d;
  logic [SLOTS-1:0]                  issued_q, issued_d;
  logic [SLOTS-1:0][OPERANDSIZE-1:0] resultQ_q, resultQ_d;
  logic [SLOTS-1:0]                  mask_q, mask_d;
  logic [SLOTS-1:0]                  illegal_q, illegal_d;

  logic [IDXW-1:0]                   idx;
  logic                              anyPending;
  logic [SLOTS-1:0]                  idxOneHot;
  logic                              accept;

  alu_next_slot #(
    .SLOTS (SLOTS),
    .IDXW  (IDXW)
  ) u_next_slot (
    .enable (enable_q),
    .issued (issued_q),
    .index  (idx),
    .any    (anyPending)
  );

  assign idxOneHot       = SLOTS'(1) << idx;
  assign bus.bundleReady = (state_q == ST_IDLE) && rstN;
  assign accept          = bus.bundleValid && bus.bundleReady;
  assign bus.resultValid = (state_q == ST_DONE);
  assign bus.resultQ       = resultQ_q;
  assign bus.resultMask    = mask_q;
  assign bus.resultIllegal = illegal_q;

  // State and datapath register; reset discards any bundle in flight.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q   <= ST_IDLE;
      enable_q  <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      issued_q  <= '0;
      resultQ_q <= '0;
      mask_q    <= '0;
      illegal_q <= '0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      issued_q  <= issued_d;
      resultQ_q <= resultQ_d;
      mask_q    <= mask_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and ALU drive. A new bundle clears the previous results so
  // skipped slots read zero; in ISSUE the selected slot drives the ALU and
  // its result is captured at the same edge that marks it issued.
  always_comb begin
    state_d   = state_q;
    enable_d  = enable_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    issued_d  = issued_q;
    resultQ_d = resultQ_q;
    mask_d    = mask_q;
    illegal_d = illegal_q;
    bus.aluA  = '0;
    bus.aluB  = '0;
    bus.aluOp = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          enable_d  = bus.bundleEnable;
          op_d      = bus.bundleOp;
          a_d       = bus.bundleA;
          b_d       = bus.bundleB;
          issued_d  = '0;
          resultQ_d = '0;
          mask_d    = '0;
          illegal_d = '0;
          state_d   = (|bus.bundleEnable) ? ST_ISSUE : ST_DONE;
        end
      end

      ST_ISSUE: begin
        if (anyPending) begin
          bus.aluA            = a_q[idx];
          bus.aluB            = b_q[idx];
          bus.aluOp           = op_q[idx];
          resultQ_d[idx]      = bus.aluQ;
          mask_d[idx]         = 1'b1;
          illegal_d[idx]      = isIllegal(op_q[idx]);
          issued_d            = issued_q | idxOneHot;
          if ((enable_q & ~issued_q & ~idxOneHot) == '0) begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.resultReady) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_bundle_issue.sv
// tb_alu_bundle_issue: scoreboard bench for alu_bundle_issue with a
// behavioural external ALU. Expected result bundles are queued when a
// bundle is driven and compared when the block raises resultValid.
module tb_alu_bundle_issue;
  import alu_pkg::*;

  localparam int OS = 64;
  localparam int SL = 4;

  typedef struct {
    logic [255:0] q;
    logic [3:0]   mask;
    logic [3:0]   illegal;
    int           latency;
  } exp_t;

  logic clk;
  logic rstN;
  int   checks;
  int   failures;
  exp_t sb[$];

  alu_bundle_issue_if #(.OPERANDSIZE(OS), .SLOTS(SL)) busIf ();

  alu_bundle_issue #(.OPERANDSIZE(OS), .SLOTS(SL)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (busIf.slave)
  );

  // Behavioural external ALU: illegal opcodes produce zero.
  function automatic logic [63:0] aluModel(input logic [11:0] op,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
    case (op)
      12'd0:   return a + b;
      12'd1:   return a ^ b;
      12'd2:   return a & b;
      12'd3:   return a | b;
      default: return 64'd0;
    endcase
  endfunction

  assign busIf.aluQ = aluModel(busIf.aluOp, busIf.aluA, busIf.aluB);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic driveGarbage();
    busIf.bundleValid  = 1'b1;
    busIf.bundleEnable = 4'($urandom);
    for (int s = 0; s < SL; s++) begin
      busIf.bundleOp[s] = 12'($urandom);
      busIf.bundleA[s]  = {$urandom, $urandom};
      busIf.bundleB[s]  = {$urandom, $urandom};
    end
  endtask

  // Drive one bundle, queue its expected result, then consume the result
  // after holding resultReady low for 'hold' cycles.
  task automatic applyStimulus(input logic [3:0] en, input logic [3:0][11:0] ops,
                               input logic [255:0] a, input logic [255:0] b,
                               input int hold);
    exp_t         e;
    int           lat;
    logic         sawOp;
    logic [255:0] snapQ;
    e.q = '0; e.mask = '0; e.illegal = '0;
    for (int s = 0; s < SL; s++) begin
      if (en[s]) begin
        e.q[s*64 +: 64] = aluModel(ops[s], a[s*64 +: 64], b[s*64 +: 64]);
        e.mask[s]       = 1'b1;
        e.illegal[s]    = (ops[s] > 12'd3);
      end
    end
    e.latency = ($countones(en) == 0) ? 1 : $countones(en);
    sb.push_back(e);

    @(negedge clk);
    busIf.bundleValid  = 1'b1;
    busIf.bundleEnable = en;
    busIf.bundleOp     = ops;
    busIf.bundleA      = a;
    busIf.bundleB      = b;
    checkOutput("ready_in_idle", 256'(busIf.bundleReady), 256'(1));
    @(posedge clk);
    #1;
    driveGarbage();

    lat   = 0;
    sawOp = 1'b0;
    do begin
      @(negedge clk);
      if (busIf.aluOp != 12'd0) sawOp = 1'b1;
      @(posedge clk);
      lat++;
      #1;
    end while (!busIf.resultValid && lat < 20);

    @(negedge clk);
    if (sb.size() == 0) begin
      checkOutput("sb_not_empty", 256'(0), 256'(1));
    end else begin
      e = sb.pop_front();
      checkOutput("latency", 256'(lat), 256'(e.latency));
      checkOutput("result_valid", 256'(busIf.resultValid), 256'(1));
      checkOutput("resultQ", busIf.resultQ, e.q);
      checkOutput("resultMask", 256'(busIf.resultMask), 256'(e.mask));
      checkOutput("resultIllegal", 256'(busIf.resultIllegal), 256'(e.illegal));
    end
    checkOutput("done_aluop_zero", 256'({busIf.aluOp, busIf.aluA, busIf.aluB}), 256'(0));
    checkOutput("done_not_ready", 256'(busIf.bundleReady), 256'(0));
    if (en == 4'b0000) checkOutput("no_aluop_driven", 256'(sawOp), 256'(0));
    snapQ = busIf.resultQ;

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("hold_q", busIf.resultQ, snapQ);
      checkOutput("hold_valid_ready", 256'({busIf.resultValid, busIf.bundleReady}),
                  256'(2'b10));
    end

    busIf.resultReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    busIf.resultReady = 1'b0;
    checkOutput("back_to_idle", 256'({busIf.resultValid, busIf.bundleReady}),
                256'(2'b01));
    busIf.bundleValid = 1'b0;
  endtask

  // Reset asserted while the second slot of a four-slot bundle is issuing.
  task automatic applyResetMidBundle();
    logic stale;
    @(negedge clk);
    busIf.bundleValid  = 1'b1;
    busIf.bundleEnable = 4'b1111;
    busIf.bundleOp     = {12'd3, 12'd2, 12'd1, 12'd0};
    busIf.bundleA      = {4{64'hF0}};
    busIf.bundleB      = {4{64'h3C}};
    @(posedge clk);
    #1;
    busIf.bundleValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_issue_slot1_op", 256'(busIf.aluOp), 256'(1));
    rstN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_results", {busIf.resultQ[3:1], busIf.resultQ[0]}, 256'(0));
    checkOutput("rst_flags", 256'({busIf.resultValid, busIf.resultMask,
                busIf.resultIllegal, busIf.bundleReady}), 256'(0));
    checkOutput("rst_aluop", 256'(busIf.aluOp), 256'(0));
    rstN = 1'b1;
    #1;
    checkOutput("ready_after_rst", 256'(busIf.bundleReady), 256'(1));
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (busIf.resultValid || busIf.resultMask != 4'b0) stale = 1'b1;
    end
    checkOutput("no_stale_result", 256'(stale), 256'(0));
  endtask

  initial begin
    logic [3:0][11:0] ops;
    logic [255:0]     a;
    logic [255:0]     b;
    checks   = 0;
    failures = 0;
    rstN               = 1'b0;
    busIf.bundleValid  = 1'b0;
    busIf.bundleEnable = '0;
    busIf.bundleOp     = '0;
    busIf.bundleA      = '0;
    busIf.bundleB      = '0;
    busIf.resultReady  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_flags", 256'({busIf.resultValid, busIf.resultMask,
                busIf.resultIllegal, busIf.bundleReady}), 256'(0));
    checkOutput("reset_resultQ", busIf.resultQ, 256'(0));
    rstN = 1'b1;
    #1;
    checkOutput("reset_release_ready", 256'(busIf.bundleReady), 256'(1));

    // All four legal ops on 0xF0 / 0x3C.
    applyStimulus(4'b1111, {12'd3, 12'd2, 12'd1, 12'd0},
                  {4{64'hF0}}, {4{64'h3C}}, 0);
    // Sparse enable: slot0 ADD 5+7, slot2 OR 1|8.
    applyStimulus(4'b0101, {12'd0, 12'd3, 12'd0, 12'd0},
                  {64'd0, 64'd1, 64'd0, 64'd5}, {64'd0, 64'd8, 64'd0, 64'd7}, 0);
    // Empty bundle, non-zero opcodes present but disabled.
    applyStimulus(4'b0000, {12'd1, 12'd2, 12'd3, 12'd7},
                  {4{64'h11}}, {4{64'h22}}, 0);
    // Illegal opcode in slot 1.
    applyStimulus(4'b0010, {12'd0, 12'd0, 12'd7, 12'd0},
                  {64'd0, 64'd0, 64'd3, 64'd0}, {64'd0, 64'd0, 64'd4, 64'd0}, 0);
    // Consumer stalls five cycles in DONE.
    applyStimulus(4'b1011, {12'd2, 12'd0, 12'd1, 12'd0},
                  {64'hFFFF_0000_1234_5678, 64'd9, 64'hA5A5, 64'hFFFF_FFFF_FFFF_FFFF},
                  {64'h0F0F_0F0F_0F0F_0F0F, 64'd1, 64'h5A5A, 64'd1}, 5);

    applyResetMidBundle();

    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < SL; s++) begin
        ops[s]          = 12'($urandom_range(0, 5));
        a[s*64 +: 64]   = {$urandom, $urandom};
        b[s*64 +: 64]   = {$urandom, $urandom};
      end
      applyStimulus(4'($urandom), ops, a, b, int'($urandom_range(0, 2)));
    end

    checkOutput("scoreboard_drained", 256'(sb.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
